// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Optional blink support is compiled in when SEG7_BLINK_EN is defined; it adds
// a per-digit blink field to the display buffer.
package seg7_pkg;

    // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    typedef logic [1:0] digit_idx_t;

    // One complete display image; used for both the shadow and active copies
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
`ifdef SEG7_BLINK_EN
        logic [3:0]  blink;
`endif
    } disp_buf_t;

    // Hex digit to active-low segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    hex_to_seg = SEG_HEX_0;
            4'h1:    hex_to_seg = SEG_HEX_1;
            4'h2:    hex_to_seg = SEG_HEX_2;
            4'h3:    hex_to_seg = SEG_HEX_3;
            4'h4:    hex_to_seg = SEG_HEX_4;
            4'h5:    hex_to_seg = SEG_HEX_5;
            4'h6:    hex_to_seg = SEG_HEX_6;
            4'h7:    hex_to_seg = SEG_HEX_7;
            4'h8:    hex_to_seg = SEG_HEX_8;
            4'h9:    hex_to_seg = SEG_HEX_9;
            4'hA:    hex_to_seg = SEG_HEX_A;
            4'hB:    hex_to_seg = SEG_HEX_B;
            4'hC:    hex_to_seg = SEG_HEX_C;
            4'hD:    hex_to_seg = SEG_HEX_D;
            4'hE:    hex_to_seg = SEG_HEX_E;
            default: hex_to_seg = SEG_HEX_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational hex-to-segment encoder with a blanking override.
module seg7_hex_encode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Blanking wins over the decoded digit so the selected slot stays dark
    always_comb begin
        o_seg = i_blank ? SEG_BLANK : hex_to_seg(i_nibble);
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// A prescaler divides clk into digit slots, each starting with a few dark
// cycles to stop ghosting. Display data is double-buffered and only swapped
// at frame boundaries (or immediately while scanning is disabled).
// Define SEG7_BLINK_EN to add the blink_i port and the BLINK_FRAMES phase timer.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16,
    parameter bit LZ_BLANK    = 1'b0
`ifdef SEG7_BLINK_EN
    ,parameter int BLINK_FRAMES = 60
`endif
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
`ifdef SEG7_BLINK_EN
    input  logic [3:0]  blink_i,
`endif
    input  logic        load_i,
    output logic [3:0]  anode_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [1:0]  digit_o,
    output logic        frame_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] r_count;
    digit_idx_t       r_index;
    disp_buf_t        r_shadow;
    disp_buf_t        r_active;
    logic             r_pending;

    disp_buf_t        w_inputs;
    logic             w_tick;
    logic             w_boundary;
    logic             w_commit;
    logic [3:0]       w_nibble;
    logic             w_leadZero;
    logic             w_blinkOff;
    logic             w_blank;
    logic [6:0]       w_seg;

    assign w_tick     = enable_i && (r_count == CNT_W'(REFRESH_DIV - 1));
    assign w_boundary = w_tick && (r_index == 2'd3);
    // While dark there is no frame to tear, so updates go straight through
    assign w_commit   = w_boundary || !enable_i;

    // Gather the loadable inputs into one display image
    always_comb begin
        w_inputs       = '0;
        w_inputs.value = value_i;
        w_inputs.dp    = dp_i;
        w_inputs.blank = blank_i;
`ifdef SEG7_BLINK_EN
        w_inputs.blink = blink_i;
`endif
    end

    // Prescaler and digit index advance only while scanning is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_index <= '0;
        end else if (enable_i) begin
            if (w_tick) begin
                r_count <= '0;
                r_index <= r_index + 2'd1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Shadow/active double buffer; a load on the commit cycle bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load_i) begin
                r_shadow <= w_inputs;
            end
            if (w_commit) begin
                if (load_i) begin
                    r_active <= w_inputs;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (load_i) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] r_blinkCount;
    logic               r_blinkOn;

    // Blink phase toggles after every BLINK_FRAMES frame boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blinkCount <= '0;
            r_blinkOn    <= 1'b1;
        end else if (w_boundary) begin
            if (r_blinkCount == BLINK_W'(BLINK_FRAMES - 1)) begin
                r_blinkCount <= '0;
                r_blinkOn    <= ~r_blinkOn;
            end else begin
                r_blinkCount <= r_blinkCount + 1'b1;
            end
        end
    end

    assign w_blinkOff = !r_blinkOn && r_active.blink[r_index];
`else
    assign w_blinkOff = 1'b0;
`endif

    assign w_nibble = r_active.value[{r_index, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        w_leadZero = 1'b0;
        case (r_index)
            2'd3:    w_leadZero = (r_active.value[15:12] == '0);
            2'd2:    w_leadZero = (r_active.value[15:8] == '0);
            2'd1:    w_leadZero = (r_active.value[15:4] == '0);
            default: w_leadZero = 1'b0;
        endcase
    end

    assign w_blank = r_active.blank[r_index] || (LZ_BLANK && w_leadZero) || w_blinkOff;

    seg7_hex_encode u_hexEncode (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_seg)
    );

    // Register all display outputs; the anode stays lit for blanked digits for even brightness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_o <= ANODE_OFF;
            seg_o   <= SEG_BLANK;
            dp_o    <= 1'b1;
            digit_o <= '0;
            frame_o <= 1'b0;
        end else begin
            digit_o <= r_index;
            frame_o <= w_boundary;
            if (!enable_i) begin
                anode_o <= ANODE_OFF;
                seg_o   <= SEG_BLANK;
                dp_o    <= 1'b1;
            end else begin
                anode_o <= (r_count < CNT_W'(DEAD_CYCLES)) ? ANODE_OFF : ~(4'b0001 << r_index);
                seg_o   <= w_seg;
                dp_o    <= w_blank ? 1'b1 : ~r_active.dp[r_index];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed testbench for seg7_scan_controller with a 4-cycle slot and one
// dead cycle. A second instance with leading-zero suppression shares all inputs.
module tb_seg7_scan_controller;

    localparam int REFRESH_DIV = 4;
    localparam int DEAD_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b1;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic [3:0]  blink_i = '0;
    logic        load_i = 1'b0;

    logic [3:0]  anode_o, lzAnode;
    logic [6:0]  seg_o, lzSeg;
    logic        dp_o, lzDp;
    logic [1:0]  digit_o, lzDigit;
    logic        frame_o, lzFrame;

    int assertCount = 0;
    int failCount = 0;

    logic [6:0] hexSeg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [3:0] anodeOn [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg7_scan_controller #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .LZ_BLANK    (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable_i),
        .value_i  (value_i),
        .dp_i     (dp_i),
        .blank_i  (blank_i),
`ifdef SEG7_BLINK_EN
        .blink_i  (blink_i),
`endif
        .load_i   (load_i),
        .anode_o  (anode_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .digit_o  (digit_o),
        .frame_o  (frame_o)
    );

    seg7_scan_controller #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .LZ_BLANK    (1'b1)
    ) dutLz (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable_i),
        .value_i  (value_i),
        .dp_i     (dp_i),
        .blank_i  (blank_i),
`ifdef SEG7_BLINK_EN
        .blink_i  (blink_i),
`endif
        .load_i   (load_i),
        .anode_o  (lzAnode),
        .seg_o    (lzSeg),
        .dp_o     (lzDp),
        .digit_o  (lzDigit),
        .frame_o  (lzFrame)
    );

    // Free-running clock, posedge is the active edge
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse load_i for one cycle after waiting a number of edges
    task automatic applyStimulus(input int waitEdges, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blank);
        repeat (waitEdges) step();
        value_i = v;
        dp_i    = dp;
        blank_i = blank;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
    endtask

    // Walk one digit slot: one dark cycle then three lit cycles
    task automatic runSlot(input int d, input logic [6:0] seg1, input logic dp1, input logic [6:0] seg2, input logic dp2);
        for (int p = 0; p < 4; p++) begin
            step();
            checkOutput($sformatf("anode d%0d p%0d", d, p), anode_o, (p == 0) ? 4'b1111 : anodeOn[d]);
            checkOutput($sformatf("digit d%0d p%0d", d, p), digit_o, 16'(d));
            checkOutput($sformatf("frame d%0d p%0d", d, p), frame_o, 16'((d == 3) && (p == 3)));
            checkOutput($sformatf("lzAnode d%0d p%0d", d, p), lzAnode, (p == 0) ? 4'b1111 : anodeOn[d]);
            if (p > 0) begin
                checkOutput($sformatf("seg d%0d p%0d", d, p), seg_o, seg1);
                checkOutput($sformatf("dp d%0d p%0d", d, p), dp_o, dp1);
                checkOutput($sformatf("lzSeg d%0d p%0d", d, p), lzSeg, seg2);
                checkOutput($sformatf("lzDp d%0d p%0d", d, p), lzDp, dp2);
            end
        end
    endtask

    // Walk a whole frame expecting the given image on both instances
    task automatic runFrame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blank);
        logic [3:0] nib;
        logic       lz;
        logic [6:0] seg1, seg2;
        logic       dp1, dp2;
        for (int d = 0; d < 4; d++) begin
            nib  = v[4*d +: 4];
            seg1 = blank[d] ? 7'h7F : hexSeg[nib];
            dp1  = blank[d] ? 1'b1 : ~dp[d];
            lz   = (d > 0) && ((v >> (4*d)) == 16'h0);
            seg2 = (blank[d] || lz) ? 7'h7F : hexSeg[nib];
            dp2  = (blank[d] || lz) ? 1'b1 : ~dp[d];
            runSlot(d, seg1, dp1, seg2, dp2);
        end
    endtask

    // Main directed sequence
    initial begin
        $display("[TB] start");
        step();
        step();
        checkOutput("reset anode", anode_o, 4'b1111);
        checkOutput("reset seg", seg_o, 7'h7F);
        checkOutput("reset dp", dp_o, 1'b1);
        checkOutput("reset digit", digit_o, 2'd0);
        checkOutput("reset frame", frame_o, 1'b0);
        rst_n = 1'b1;

        // Load at frame start is held back until the boundary
        fork
            runFrame(16'h0000, 4'b0000, 4'b0000);
            applyStimulus(0, 16'h1A2F, 4'b0100, 4'b0000);
        join

        // Two loads within one frame: the later one wins
        fork
            runFrame(16'h1A2F, 4'b0100, 4'b0000);
            applyStimulus(2, 16'h1111, 4'b0000, 4'b0000);
            applyStimulus(8, 16'h2222, 4'b0000, 4'b0000);
        join

        // Load coincident with the boundary is committed directly
        fork
            runFrame(16'h2222, 4'b0000, 4'b0000);
            applyStimulus(15, 16'h3333, 4'b0000, 4'b1000);
        join
        runFrame(16'h3333, 4'b0000, 4'b1000);

        // Partial frame, then freeze mid-slot of digit 2
        runSlot(0, 7'b0110000, 1'b1, 7'b0110000, 1'b1);
        runSlot(1, 7'b0110000, 1'b1, 7'b0110000, 1'b1);
        step();
        checkOutput("d2 dark", anode_o, 4'b1111);
        step();
        checkOutput("d2 lit", anode_o, 4'b1011);
        checkOutput("d2 seg", seg_o, 7'b0110000);

        enable_i = 1'b0;
        value_i  = 16'hBEEF;
        dp_i     = 4'b0000;
        blank_i  = 4'b0000;
        load_i   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            load_i = 1'b0;
            checkOutput($sformatf("off anode %0d", i), anode_o, 4'b1111);
            checkOutput($sformatf("off seg %0d", i), seg_o, 7'h7F);
            checkOutput($sformatf("off dp %0d", i), dp_o, 1'b1);
            checkOutput($sformatf("off frame %0d", i), frame_o, 1'b0);
        end
        checkOutput("off digit held", digit_o, 2'd2);

        // Resume at the held slot showing the committed BEEF
        enable_i = 1'b1;
        step();
        checkOutput("resume anode", anode_o, 4'b1011);
        checkOutput("resume seg", seg_o, 7'b0000110);
        checkOutput("resume dp", dp_o, 1'b1);
        step();
        checkOutput("resume anode2", anode_o, 4'b1011);
        checkOutput("resume seg2", seg_o, 7'b0000110);
        runSlot(3, 7'b0000011, 1'b1, 7'b0000011, 1'b1);
        step();
        checkOutput("beef d0 dark", anode_o, 4'b1111);
        step();
        checkOutput("beef d0 anode", anode_o, 4'b1110);
        checkOutput("beef d0 seg", seg_o, 7'b0001110);

        // Asynchronous reset mid-slot darkens outputs without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async anode", anode_o, 4'b1111);
        checkOutput("async seg", seg_o, 7'h7F);
        checkOutput("async dp", dp_o, 1'b1);
        checkOutput("async digit", digit_o, 2'd0);
        checkOutput("async lzAnode", lzAnode, 4'b1111);
        step();
        step();
        rst_n = 1'b1;

        // Restart from digit 0 with cleared buffers, then leading-zero cases
        fork
            runFrame(16'h0000, 4'b0000, 4'b0000);
            applyStimulus(0, 16'h0070, 4'b0000, 4'b0000);
        join
        runFrame(16'h0070, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
